// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the pipelined approximate multiplier.
package approx_mul_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Rounding constant added back in approx mode: half the weight of the lowest kept column.
    function automatic int unsigned comp_const(input int unsigned trunc_cols);
        return (trunc_cols == 0) ? 32'd0 : (32'd1 << (trunc_cols - 1));
    endfunction

endpackage

// File: rtl/approx_mul_pipe_if.sv
// Operand/result handshake bundle for approx_mul_pipe.
interface approx_mul_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
);
    import approx_mul_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_mode;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic [TAG_W-1:0]     out_tag;
    logic [CNT_W-1:0]     approx_cnt;

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, approx_cnt
    );

    // Multiplier side
    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, approx_cnt
    );

endinterface

// File: rtl/approx_mul_pipe_pp_array.sv
// Combinational partial-product generator with approx-mode column truncation.
module approx_pp_array
    import approx_mul_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TRUNC_COLS = 4
) (
    input  logic [WIDTH-1:0]                a_i,
    input  logic [WIDTH-1:0]                b_i,
    input  mode_e                           mode_i,
    output logic [WIDTH-1:0][2*WIDTH-1:0]   rows_o
);

    // Row i is a[i] & b placed at column offset i; approx mode clears columns below TRUNC_COLS.
    always_comb begin
        rows_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
                if (mode_i == MODE_EXACT || (i + j) >= int'(TRUNC_COLS)) begin
                    rows_o[i][i+j] = a_i[i] & b_i[j];
                end
            end
        end
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned exact/approximate multiplier with valid/ready handshake and tag sideband.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TRUNC_COLS = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned TAG_W      = 4
) (
    input logic               clk,
    input logic               rst,
    approx_mul_pipe_if.slave  bus
);

    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned LO_ROWS = WIDTH / 2;
    localparam logic [PW:0] COMP    = (PW + 1)'(comp_const(TRUNC_COLS));

    // Whole pipe moves as one; a stalled output freezes every stage.
    logic adv;
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    // ---------------- S1: operands, mode, tag ----------------
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    mode_e            s1_mode;
    logic [TAG_W-1:0] s1_tag;

    if (STAGES >= 3) begin : g_s1_reg
        logic             valid_q;
        logic [WIDTH-1:0] a_q, b_q;
        mode_e            mode_q;
        logic [TAG_W-1:0] tag_q;

        // Capture the incoming beat.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                a_q     <= '0;
                b_q     <= '0;
                mode_q  <= MODE_EXACT;
                tag_q   <= '0;
            end else if (adv) begin
                valid_q <= bus.in_valid;
                a_q     <= bus.in_a;
                b_q     <= bus.in_b;
                mode_q  <= mode_e'(bus.in_mode);
                tag_q   <= bus.in_tag;
            end
        end

        assign s1_valid = valid_q;
        assign s1_a     = a_q;
        assign s1_b     = b_q;
        assign s1_mode  = mode_q;
        assign s1_tag   = tag_q;
    end else begin : g_s1_pass
        assign s1_valid = bus.in_valid;
        assign s1_a     = bus.in_a;
        assign s1_b     = bus.in_b;
        assign s1_mode  = mode_e'(bus.in_mode);
        assign s1_tag   = bus.in_tag;
    end

    // ---------------- partial products and row reduction ----------------
    logic [WIDTH-1:0][PW-1:0] rows;
    logic [PW-1:0]            red_lo, red_hi;
    logic                     red_zero;

    approx_pp_array #(
        .WIDTH      (WIDTH),
        .TRUNC_COLS (TRUNC_COLS)
    ) u_pp (
        .a_i    (s1_a),
        .b_i    (s1_b),
        .mode_i (s1_mode),
        .rows_o (rows)
    );

    // Fold rows into two partial sums; each fits PW bits since it never exceeds the full product.
    always_comb begin
        red_lo = '0;
        red_hi = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(LO_ROWS)) begin
                red_lo = red_lo + rows[i];
            end else begin
                red_hi = red_hi + rows[i];
            end
        end
    end

    assign red_zero = (s1_a == '0) || (s1_b == '0);

    // ---------------- S2: reduced rows ----------------
    logic             s2_valid;
    logic [PW-1:0]    s2_lo, s2_hi;
    logic             s2_zero;
    mode_e            s2_mode;
    logic [TAG_W-1:0] s2_tag;

    if (STAGES >= 2) begin : g_s2_reg
        logic             valid_q;
        logic [PW-1:0]    lo_q, hi_q;
        logic             zero_q;
        mode_e            mode_q;
        logic [TAG_W-1:0] tag_q;

        // Register the two partial sums with their sideband.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                lo_q    <= '0;
                hi_q    <= '0;
                zero_q  <= 1'b0;
                mode_q  <= MODE_EXACT;
                tag_q   <= '0;
            end else if (adv) begin
                valid_q <= s1_valid;
                lo_q    <= red_lo;
                hi_q    <= red_hi;
                zero_q  <= red_zero;
                mode_q  <= s1_mode;
                tag_q   <= s1_tag;
            end
        end

        assign s2_valid = valid_q;
        assign s2_lo    = lo_q;
        assign s2_hi    = hi_q;
        assign s2_zero  = zero_q;
        assign s2_mode  = mode_q;
        assign s2_tag   = tag_q;
    end else begin : g_s2_pass
        assign s2_valid = s1_valid;
        assign s2_lo    = red_lo;
        assign s2_hi    = red_hi;
        assign s2_zero  = red_zero;
        assign s2_mode  = s1_mode;
        assign s2_tag   = s1_tag;
    end

    // ---------------- final add, compensation, zero bypass ----------------
    logic [PW:0]   sum_wide;
    logic [PW-1:0] sum_p;

    // Add the compensation constant only for approx beats; clamp on any carry out.
    always_comb begin
        sum_wide = {1'b0, s2_lo} + {1'b0, s2_hi};
        if (s2_mode == MODE_APPROX) begin
            sum_wide = sum_wide + COMP;
        end
        if (s2_zero) begin
            sum_p = '0;
        end else if (sum_wide[PW]) begin
            sum_p = '1;
        end else begin
            sum_p = sum_wide[PW-1:0];
        end
    end

    // ---------------- S3: final sum ----------------
    logic             s3_valid_q;
    logic [PW-1:0]    s3_p_q;
    mode_e            s3_mode_q;
    logic [TAG_W-1:0] s3_tag_q;

    // Register the finished product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_p_q     <= '0;
            s3_mode_q  <= MODE_EXACT;
            s3_tag_q   <= '0;
        end else if (adv) begin
            s3_valid_q <= s2_valid;
            s3_p_q     <= sum_p;
            s3_mode_q  <= s2_mode;
            s3_tag_q   <= s2_tag;
        end
    end

    // ---------------- S4: optional output register ----------------
    mode_e out_mode;

    if (STAGES >= 4) begin : g_s4_reg
        logic             valid_q;
        logic [PW-1:0]    p_q;
        mode_e            mode_q;
        logic [TAG_W-1:0] tag_q;

        // Extra retiming register on the result.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                p_q     <= '0;
                mode_q  <= MODE_EXACT;
                tag_q   <= '0;
            end else if (adv) begin
                valid_q <= s3_valid_q;
                p_q     <= s3_p_q;
                mode_q  <= s3_mode_q;
                tag_q   <= s3_tag_q;
            end
        end

        assign bus.out_valid = valid_q;
        assign bus.out_p     = p_q;
        assign bus.out_tag   = tag_q;
        assign out_mode      = mode_q;
    end else begin : g_s4_pass
        assign bus.out_valid = s3_valid_q;
        assign bus.out_p     = s3_p_q;
        assign bus.out_tag   = s3_tag_q;
        assign out_mode      = s3_mode_q;
    end

    // ---------------- completed-approx-op counter ----------------
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Count consumed approx results, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.out_valid && bus.out_ready && out_mode == MODE_APPROX && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed and randomised checks of approx_mul_pipe in three configurations sharing one stimulus.
module tb_approx_mul_pipe;

    typedef struct {
        logic [23:0] p;
        logic [3:0]  tag;
        logic        mode;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v, ordy, im;
    logic [11:0] ia, ib;
    logic [3:0]  it;
    logic [23:0] exp8, exp12;
    logic        acc0, acc1, acc2;
    logic        stall0;
    logic [15:0] held_p0;
    logic [3:0]  held_t0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acnt0 = 0, acnt1 = 0, acnt2 = 0;
    int bp_cyc = 0;
    bit lat_chk = 1'b1;
    bit bp_on = 1'b0;
    exp_t q0[$], q1[$], q2[$];

    // d0: default 8x8, trunc 4, 3 stages; d1: 12x12, no truncation, 4 stages; d2: 8x8, 1 stage
    approx_mul_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus0 ();
    approx_mul_pipe_if #(.WIDTH(12), .TAG_W(4)) bus1 ();
    approx_mul_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus2 ();

    assign bus0.in_valid = v;       assign bus1.in_valid = v;       assign bus2.in_valid = v;
    assign bus0.in_a = ia[7:0];     assign bus1.in_a = ia;          assign bus2.in_a = ia[7:0];
    assign bus0.in_b = ib[7:0];     assign bus1.in_b = ib;          assign bus2.in_b = ib[7:0];
    assign bus0.in_mode = im;       assign bus1.in_mode = im;       assign bus2.in_mode = im;
    assign bus0.in_tag = it;        assign bus1.in_tag = it;        assign bus2.in_tag = it;
    assign bus0.out_ready = ordy;   assign bus1.out_ready = ordy;   assign bus2.out_ready = ordy;

    approx_mul_pipe #(.WIDTH(8), .TRUNC_COLS(4), .STAGES(3), .TAG_W(4)) d0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    approx_mul_pipe #(.WIDTH(12), .TRUNC_COLS(0), .STAGES(4), .TAG_W(4)) d1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    approx_mul_pipe #(.WIDTH(8), .TRUNC_COLS(4), .STAGES(1), .TAG_W(4)) d2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: full product minus the dropped low columns plus the rounding constant.
    function automatic logic [23:0] ref_mul(input logic [11:0] a, input logic [11:0] b,
                                            input logic m, input int w, input int t);
        logic [11:0] msk, aa, bb;
        logic [23:0] p, drop;
        msk = 12'((32'd1 << w) - 1);
        aa = a & msk;
        bb = b & msk;
        p = 24'(aa) * 24'(bb);
        if (!m) return p;
        if (aa == 12'd0 || bb == 12'd0) return 24'd0;
        drop = 24'd0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (i + j < t && aa[i] && bb[j]) drop = drop + (24'd1 << (i + j));
        return p - drop + ((t > 0) ? (24'd1 << (t - 1)) : 24'd0);
    endfunction

    task automatic sb(ref exp_t q[$], input string nm, input int lat, input logic ov,
                      input logic rdy, input logic iv, input logic ir, input logic [23:0] p,
                      input logic [3:0] tg, input logic [23:0] e, inout int acnt,
                      output logic acc);
        exp_t x;
        if (ov && rdy) begin
            if (q.size() == 0) begin
                check({nm, "_spurious_result"}, 32'(ov), 32'd0);
            end else begin
                x = q.pop_front();
                check({nm, "_p"}, 32'(p), 32'(x.p));
                check({nm, "_tag"}, 32'(tg), 32'(x.tag));
                if (lat_chk) check({nm, "_latency"}, 32'(cyc - x.cyc), 32'(lat));
                if (x.mode) acnt++;
            end
        end
        acc = iv && ir;
        if (acc) begin
            x.p = e;
            x.tag = it;
            x.mode = im;
            x.cyc = cyc;
            q.push_back(x);
        end
    endtask

    // One clock: inputs already set at a negedge; observe mid-cycle, then move to the next negedge.
    task automatic step();
        if (bp_on) begin
            ordy = !(bp_cyc >= 4 && bp_cyc <= 8);
            bp_cyc++;
        end
        #1;
        if (!rst) begin
            if (bus0.out_valid && !bus0.out_ready) begin
                check("d0_stall_in_ready", 32'(bus0.in_ready), 32'd0);
                if (stall0) begin
                    check("d0_stall_hold_p", 32'(bus0.out_p), 32'(held_p0));
                    check("d0_stall_hold_tag", 32'(bus0.out_tag), 32'(held_t0));
                end
                stall0 = 1'b1;
                held_p0 = bus0.out_p;
                held_t0 = bus0.out_tag;
            end else begin
                stall0 = 1'b0;
            end
            sb(q0, "d0", 3, bus0.out_valid, bus0.out_ready, bus0.in_valid, bus0.in_ready,
               24'(bus0.out_p), bus0.out_tag, exp8, acnt0, acc0);
            sb(q1, "d1", 4, bus1.out_valid, bus1.out_ready, bus1.in_valid, bus1.in_ready,
               bus1.out_p, bus1.out_tag, exp12, acnt1, acc1);
            sb(q2, "d2", 1, bus2.out_valid, bus2.out_ready, bus2.in_valid, bus2.in_ready,
               24'(bus2.out_p), bus2.out_tag, exp8, acnt2, acc2);
        end
        @(negedge clk);
        cyc++;
    endtask

    // Offer one beat until d0 takes it; d0 expectation given by caller, d1 from the model.
    task automatic beat(input logic [11:0] a, input logic [11:0] b, input logic m,
                        input logic [3:0] t, input logic [23:0] e8);
        int tries = 0;
        v = 1'b1; ia = a; ib = b; im = m; it = t;
        exp8 = e8;
        exp12 = ref_mul(a, b, m, 12, 0);
        do begin
            step();
            tries++;
        end while (!acc0 && tries < 20);
        if (!acc0) check("d0_accept_timeout", 32'(acc0), 32'd1);
        v = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        v = 1'b0;
        bp_on = 1'b0;
        ordy = 1'b1;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 50) begin
            step();
            n++;
        end
        check("d0_drained", 32'(q0.size()), 32'd0);
        check("d1_drained", 32'(q1.size()), 32'd0);
        check("d2_drained", 32'(q2.size()), 32'd0);
        check("d0_approx_cnt", 32'(bus0.approx_cnt), 32'(acnt0));
        check("d1_approx_cnt", 32'(bus1.approx_cnt), 32'(acnt1));
        check("d2_approx_cnt", 32'(bus2.approx_cnt), 32'(acnt2));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        v = 1'b0;
        repeat (n) step();
        q0.delete(); q1.delete(); q2.delete();
        acnt0 = 0; acnt1 = 0; acnt2 = 0;
        stall0 = 1'b0;
        check("rst_d0_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_d0_out_p", 32'(bus0.out_p), 32'd0);
        check("rst_d0_out_tag", 32'(bus0.out_tag), 32'd0);
        check("rst_d0_approx_cnt", 32'(bus0.approx_cnt), 32'd0);
        check("rst_d1_out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst_d2_out_valid", 32'(bus2.out_valid), 32'd0);
        rst = 1'b0;
        step();
        check("d0_in_ready_after_reset", 32'(bus0.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ra, rb;
        logic        rm;
        v = 1'b0; ordy = 1'b1; ia = '0; ib = '0; im = 1'b0; it = '0;
        exp8 = '0; exp12 = '0; acc0 = 1'b0; acc1 = 1'b0; acc2 = 1'b0;
        stall0 = 1'b0; held_p0 = '0; held_t0 = '0;

        do_reset(2);

        // Directed vectors, hand-computed for 8x8 / trunc 4
        beat(12'd255, 12'd255, 1'b0, 4'hA, 24'd65025);
        beat(12'd255, 12'd255, 1'b1, 4'h1, 24'd64984);
        beat(12'd200, 12'd3,   1'b1, 4'h2, 24'd600);
        beat(12'd1,   12'd1,   1'b1, 4'h3, 24'd8);
        beat(12'd0,   12'd77,  1'b1, 4'h4, 24'd0);
        beat(12'd77,  12'd0,   1'b0, 4'h5, 24'd0);
        drain();

        // Mode interleave on 255*255
        for (int k = 0; k < 6; k++) begin
            beat(12'd255, 12'd255, k[0], 4'(k + 8), k[0] ? 24'd64984 : 24'd65025);
        end
        drain();

        // Back-pressure: 6 streamed beats, out_ready low for 5 cycles mid-stream
        lat_chk = 1'b0;
        bp_on = 1'b1;
        bp_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            ra = 12'(17 * k + 9);
            rb = 12'(29 * k + 5);
            beat(ra, rb, k[0], 4'(k + 6), ref_mul(ra, rb, k[0], 8, 4));
        end
        drain();
        lat_chk = 1'b1;

        // Reset with three beats in flight; nothing stale may emerge afterwards
        beat(12'd255, 12'd255, 1'b1, 4'hC, 24'd64984);
        beat(12'd200, 12'd3,   1'b1, 4'hD, 24'd600);
        beat(12'd1,   12'd1,   1'b1, 4'hE, 24'd8);
        do_reset(1);
        repeat (6) step();
        drain();

        // Random sweep across all three configurations
        for (int k = 0; k < 80; k++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            rm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                step();
            end else begin
                beat(ra, rb, rm, 4'(k), ref_mul(ra, rb, rm, 8, 4));
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
